td4_run_ctrl: RTL and testbench
===============================

TD4_RUN_CTRL -- requirements
Module: td4_run_ctrl

Interface
REQ-001 SHALL have parameter CYC_W, default 8, width of the executed-instruction counter.
REQ-002 SHALL have port clk  input  1  core clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd  input  2  command: 00 NOP, 01 RUN, 10 STEP, 11 HALT.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-007 SHALL have port adr  input  4  current CPU program counter.
REQ-008 SHALL have ports instr  input  4, im  input  4  opcode and immediate of the fetched instruction.
REQ-009 SHALL have port bp_adr  input  4  breakpoint address.
REQ-010 SHALL have port cpu_en  output  1  clock enable to CPU registers; one instruction executes per high cycle.
REQ-011 SHALL have port state  output  2  FSM state encoding.
REQ-012 SHALL have port stop_cause  output  2  00 none, 01 host halt, 10 breakpoint, 11 self-loop.
REQ-013 SHALL have port cycles  output  CYC_W  instructions executed since reset.

Function
REQ-014 SHALL implement states IDLE=00, RUN=01, STEP=10, STOPPED=11.
REQ-015 SHALL drive cpu_en high only in RUN and for exactly one cycle in STEP.
REQ-016 SHALL assert cmd_ready in IDLE and STOPPED; in RUN only for HALT; never in STEP.
REQ-017 SHALL in IDLE/STOPPED on accepted RUN go to RUN next cycle, stop_cause cleared to 00.
REQ-018 SHALL in IDLE/STOPPED on accepted STEP go to STEP, assert cpu_en one cycle, then go to STOPPED, stop_cause 00.
REQ-019 SHALL in RUN on accepted HALT go to STOPPED with stop_cause 01; cpu_en low from that edge on.
REQ-020 SHALL treat NOP and HALT accepted in IDLE/STOPPED as no state change.
REQ-021 SHALL detect self-loop when instr==4'b1111 and im==adr while cpu_en high; that instruction executes, then STOPPED, stop_cause 11.
REQ-022 SHALL on simultaneous HALT and self-loop/breakpoint report highest priority cause: breakpoint > self-loop > host halt.
REQ-023 SHALL increment cycles on every cpu_en-high cycle, wrapping from all-ones to zero.
REQ-024 SHALL have zero-cycle combinational paths only from state to cpu_en/cmd_ready; stop conditions registered (one-cycle latency).

Reset
REQ-025 SHALL on reset asynchronously force state IDLE, cpu_en 0, cmd_ready 1, stop_cause 00, cycles 0.
REQ-026 SHALL on reset mid-RUN or mid-STEP drop cpu_en immediately, without completing the step.

Configuration
REQ-027 SHALL, with TD4_BREAKPOINT_EN defined, stop in RUN when adr==bp_adr before executing it (cpu_en low that cycle), state STOPPED, stop_cause 10; RUN issued at adr==bp_adr executes at least one instruction before rechecking.
REQ-028 SHALL, without TD4_BREAKPOINT_EN, ignore bp_adr and never report cause 10.

Structure
REQ-029 SHALL place state enum, cmd encoding and stop_cause encoding in shared package td4_pkg.
REQ-030 SHALL use sub-module td4_cyc_cnt (CYC_W-bit enabled wrapping counter with async reset).

Verification
REQ-031 SHALL test reset then RUN, adr sequence 0,1,2, HALT after 3 cycles -> STOPPED, stop_cause 01, cycles 3.
REQ-032 SHALL test STEP from IDLE -> cpu_en high exactly 1 cycle, cycles 1, cmd_ready low during STEP.
REQ-033 SHALL test RUN with instr 1111, im 5 at adr 5 -> STOPPED, stop_cause 11, one cpu_en cycle at adr 5.
REQ-034 SHALL test (macro on) bp_adr 3, RUN from 0 -> stop with adr 3 unexecuted, stop_cause 10; second RUN passes adr 3.
REQ-035 SHALL test CYC_W 4, 17 executed instructions -> cycles 1 (wrap).
REQ-036 SHALL test reset asserted mid-RUN -> cpu_en 0 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared encodings for the TD4 run controller: FSM states, host commands, stop causes.
package td4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_STEP    = 2'b10,
    ST_STOPPED = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_STEP = 2'b10,
    CMD_HALT = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_HOST = 2'b01,
    CAUSE_BP   = 2'b10,
    CAUSE_LOOP = 2'b11
  } cause_t;

  localparam logic [3:0] OP_JMP = 4'b1111;

  // A jump-immediate whose target is its own address never leaves this instruction.
  function automatic logic is_self_loop(input logic [3:0] instr, input logic [3:0] im,
                                        input logic [3:0] adr);
    return (instr == OP_JMP) && (im == adr);
  endfunction

endpackage

// File: rtl/td4_cyc_cnt.sv
// Enabled, wrapping executed-instruction counter with asynchronous active-high reset.
module td4_cyc_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (en) count <= count + 1'b1;
  end

endmodule

// File: rtl/td4_run_ctrl.sv
// TD4 run controller: host RUN/STEP/HALT, self-loop stop, optional breakpoint.
// Optional breakpoint stop is built only when TD4_BREAKPOINT_EN is defined.
module td4_run_ctrl
  import td4_pkg::*;
#(
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       adr,
  input  logic [3:0]       instr,
  input  logic [3:0]       im,
  input  logic [3:0]       bp_adr,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [1:0]       stop_cause,
  output logic [CYC_W-1:0] cycles
);

  // Handshake: a command is consumed on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready never depends on cmd_valid, and an unaccepted command has no effect.
  state_t state_q;
  cause_t cause_q;
  logic   in_run;
  logic   in_wait;
  logic   bp_hit;
  logic   self_loop;
  logic   cmd_acc;

  assign in_run  = (state_q == ST_RUN);
  assign in_wait = (state_q == ST_IDLE) || (state_q == ST_STOPPED);

`ifdef TD4_BREAKPOINT_EN
  logic bp_skip_q;

  // The breakpoint gates the current fetch, so it must act combinationally on adr.
  assign bp_hit = in_run && !bp_skip_q && (adr == bp_adr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bp_skip_q <= 1'b0;
    else if (in_wait && cmd_valid && (cmd_t'(cmd) == CMD_RUN)) bp_skip_q <= 1'b1;
    else if (cpu_en) bp_skip_q <= 1'b0;
  end
`else
  logic unused_bp;
  assign unused_bp = ^bp_adr;
  assign bp_hit    = 1'b0;
`endif

  assign cpu_en     = (in_run && !bp_hit) || (state_q == ST_STEP);
  assign cmd_ready  = in_wait || (in_run && (cmd_t'(cmd) == CMD_HALT));
  assign cmd_acc    = cmd_valid && cmd_ready;
  assign self_loop  = cpu_en && is_self_loop(instr, im, adr);
  assign state      = state_q;
  assign stop_cause = cause_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_STOPPED: begin
          if (cmd_acc && (cmd_t'(cmd) == CMD_RUN)) begin
            state_q <= ST_RUN;
            cause_q <= CAUSE_NONE;
          end else if (cmd_acc && (cmd_t'(cmd) == CMD_STEP)) begin
            state_q <= ST_STEP;
            cause_q <= CAUSE_NONE;
          end
        end
        ST_RUN: begin
          // Priority when several stop reasons coincide: breakpoint, self-loop, host.
          if (bp_hit) begin
            state_q <= ST_STOPPED;
            cause_q <= CAUSE_BP;
          end else if (self_loop) begin
            state_q <= ST_STOPPED;
            cause_q <= CAUSE_LOOP;
          end else if (cmd_acc) begin
            state_q <= ST_STOPPED;
            cause_q <= CAUSE_HOST;
          end
        end
        default: begin
          state_q <= ST_STOPPED;
          cause_q <= self_loop ? CAUSE_LOOP : CAUSE_NONE;
        end
      endcase
    end
  end

  td4_cyc_cnt #(.W(CYC_W)) u_cyc_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cpu_en),
    .count (cycles)
  );

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Bench for td4_run_ctrl: acts as a tiny TD4 fetch model, checks traces against a program-level reference.
module tb_td4_run_ctrl;
  import td4_pkg::*;

`ifdef TD4_BREAKPOINT_EN
  localparam logic BP_ON = 1'b1;
`else
  localparam logic BP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_valid = 1'b0;
  logic [3:0] adr = 4'd0, instr = 4'd0, im = 4'd0, bp_adr = 4'd15;
  logic       cmd_ready, cpu_en;
  logic [1:0] state, stop_cause;
  logic [7:0] cycles;
  logic       cmd_ready4, cpu_en4;
  logic [1:0] state4, stop_cause4;
  logic [3:0] cycles4;

  td4_run_ctrl dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .adr(adr), .instr(instr), .im(im), .bp_adr(bp_adr), .cpu_en(cpu_en),
    .state(state), .stop_cause(stop_cause), .cycles(cycles)
  );

  td4_run_ctrl #(.CYC_W(4)) dut4 (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
    .adr(adr), .instr(instr), .im(im), .bp_adr(bp_adr), .cpu_en(cpu_en4),
    .state(state4), .stop_cause(stop_cause4), .cycles(cycles4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [3:0] pc;
  logic [3:0] prog_i[16];
  logic [3:0] prog_m[16];
  logic [3:0] exp_q[$];
  logic [3:0] act_q[$];
  int ready_bad;
  logic timed_out;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [1:0] c);
    cmd_valid = v;
    cmd       = c;
    adr       = pc;
    instr     = prog_i[pc];
    im        = prog_m[pc];
    #1;
  endtask

  task automatic step_edge();
    logic en;
    en = cpu_en;
    @(posedge clk);
    #1;
    if (en) pc = (instr == 4'hF) ? im : pc + 4'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc = 4'd0;
  endtask

  task automatic load_linear();
    for (int i = 0; i < 16; i++) begin
      prog_i[i] = 4'd0;
      prog_m[i] = 4'd0;
    end
  endtask

  task automatic issue(input logic [1:0] c);
    drive(1'b1, c);
    step_edge();
  endtask

  task automatic run_until_stop(input int halt_at);
    int n;
    n = 0;
    act_q.delete();
    ready_bad = 0;
    timed_out = 1'b0;
    while (state != ST_STOPPED) begin
      if (n >= 60) begin
        timed_out = 1'b1;
        break;
      end
      if (n == halt_at) drive(1'b1, CMD_HALT);
      else drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)));
      if (state == ST_RUN && cmd_ready !== (cmd == CMD_HALT)) ready_bad++;
      if (cpu_en === 1'b1) act_q.push_back(adr);
      step_edge();
      n++;
    end
  endtask

  // ---------------- reference model ----------------
  // Walks the program from start: breakpoint blocks a fetch (except the first), self-loop
  // and host halt stop after the instruction executes.
  task automatic model_run(input logic [3:0] start, input int halt_at, input logic [3:0] bp,
                           output logic [1:0] cause);
    logic [3:0] p;
    p = start;
    cause = CAUSE_NONE;
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      if (BP_ON && k > 0 && p == bp) begin
        cause = CAUSE_BP;
        break;
      end
      exp_q.push_back(p);
      if (prog_i[p] == 4'hF && prog_m[p] == p) begin
        cause = CAUSE_LOOP;
        break;
      end
      if (k == halt_at) begin
        cause = CAUSE_HOST;
        break;
      end
      p = (prog_i[p] == 4'hF) ? prog_m[p] : p + 4'd1;
    end
  endtask

  function automatic logic trace_ok();
    if (act_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (act_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    drive(1'b0, CMD_NOP);
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL reset_cpu_en got=%b exp=0", cpu_en); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (stop_cause !== 2'b00) begin failures++; $display("FAIL reset_cause got=%0d exp=0", stop_cause); end
    checks++; if (cycles !== 8'd0 || cycles4 !== 4'd0) begin failures++; $display("FAIL reset_cycles got=%0d/%0d exp=0", cycles, cycles4); end
  endtask

  task automatic test_run_halt();
    do_reset();
    load_linear();
    bp_adr = 4'd15;
    issue(CMD_RUN);
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL run_enter got=%0d exp=1", state); end
    run_until_stop(2);
    exp_q = '{4'd0, 4'd1, 4'd2};
    checks++; if (!trace_ok() || timed_out) begin failures++; $display("FAIL run_halt_trace got=%p exp=%p timeout=%b", act_q, exp_q, timed_out); end
    checks++; if (state !== 2'b11 || stop_cause !== 2'b01) begin failures++; $display("FAIL run_halt_stop got=%0d/%0d exp=3/1", state, stop_cause); end
    checks++; if (cycles !== 8'd3) begin failures++; $display("FAIL run_halt_cycles got=%0d exp=3", cycles); end
    checks++; if (ready_bad != 0) begin failures++; $display("FAIL run_ready got=%0d bad exp=0", ready_bad); end
  endtask

  task automatic test_step();
    int en_cnt;
    do_reset();
    load_linear();
    en_cnt = 0;
    issue(CMD_STEP);
    drive(1'b1, CMD_STEP);
    checks++; if (state !== 2'b10 || cpu_en !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL step_phase got=st%0d en%b rdy%b exp=st2 en1 rdy0", state, cpu_en, cmd_ready);
    end
    if (cpu_en === 1'b1) en_cnt++;
    step_edge();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, CMD_NOP);
      if (cpu_en === 1'b1) en_cnt++;
      step_edge();
    end
    checks++; if (en_cnt != 1) begin failures++; $display("FAIL step_en_count got=%0d exp=1", en_cnt); end
    checks++; if (state !== 2'b11 || stop_cause !== 2'b00 || cycles !== 8'd1) begin
      failures++; $display("FAIL step_after got=st%0d c%0d cyc%0d exp=st3 c0 cyc1", state, stop_cause, cycles);
    end
    issue(CMD_HALT);
    checks++; if (state !== 2'b11 || stop_cause !== 2'b00) begin failures++; $display("FAIL halt_in_stopped got=%0d/%0d exp=3/0", state, stop_cause); end
  endtask

  task automatic test_self_loop();
    int at5;
    do_reset();
    load_linear();
    prog_i[5] = 4'hF;
    prog_m[5] = 4'd5;
    bp_adr = 4'd15;
    issue(CMD_RUN);
    run_until_stop(99);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    at5 = 0;
    foreach (act_q[i]) if (act_q[i] == 4'd5) at5++;
    checks++; if (!trace_ok() || at5 != 1) begin failures++; $display("FAIL loop_trace got=%p exp=%p", act_q, exp_q); end
    checks++; if (state !== 2'b11 || stop_cause !== 2'b11 || cycles !== 8'd6) begin
      failures++; $display("FAIL loop_stop got=st%0d c%0d cyc%0d exp=st3 c3 cyc6", state, stop_cause, cycles);
    end
  endtask

  task automatic test_breakpoint();
    do_reset();
    load_linear();
    bp_adr = 4'd3;
    issue(CMD_RUN);
`ifdef TD4_BREAKPOINT_EN
    run_until_stop(99);
    exp_q = '{4'd0, 4'd1, 4'd2};
    checks++; if (!trace_ok() || stop_cause !== 2'b10 || cycles !== 8'd3 || pc !== 4'd3) begin
      failures++; $display("FAIL bp_stop got=%p c%0d cyc%0d pc%0d exp=%p c2 cyc3 pc3", act_q, stop_cause, cycles, pc, exp_q);
    end
    issue(CMD_RUN);
    run_until_stop(1);
    exp_q = '{4'd3, 4'd4};
    checks++; if (!trace_ok() || stop_cause !== 2'b01 || cycles !== 8'd5) begin
      failures++; $display("FAIL bp_resume got=%p c%0d cyc%0d exp=%p c1 cyc5", act_q, stop_cause, cycles, exp_q);
    end
`else
    run_until_stop(5);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    checks++; if (!trace_ok() || stop_cause !== 2'b01 || cycles !== 8'd6) begin
      failures++; $display("FAIL bp_ignored got=%p c%0d cyc%0d exp=%p c1 cyc6", act_q, stop_cause, cycles, exp_q);
    end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    load_linear();
    prog_i[4] = 4'hF;
    prog_m[4] = 4'd0;
    bp_adr = 4'd15;
    issue(CMD_RUN);
    run_until_stop(16);
    checks++; if (act_q.size() != 17) begin failures++; $display("FAIL wrap_exec got=%0d exp=17", act_q.size()); end
    checks++; if (cycles4 !== 4'd1 || cycles !== 8'd17) begin failures++; $display("FAIL wrap_cycles got=%0d/%0d exp=1/17", cycles4, cycles); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_linear();
    bp_adr = 4'd15;
    issue(CMD_RUN);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, CMD_NOP);
      step_edge();
    end
    drive(1'b0, CMD_NOP);
    checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL mid_run_en got=%b exp=1", cpu_en); end
    reset = 1'b1;
    #1;
    checks++; if (cpu_en !== 1'b0 || state !== 2'b00 || cmd_ready !== 1'b1 || stop_cause !== 2'b00 ||
                  cycles !== 8'd0 || cycles4 !== 4'd0 || cpu_en4 !== 1'b0 || state4 !== 2'b00) begin
      failures++; $display("FAIL async_reset got=en%b st%0d rdy%b c%0d cyc%0d exp=en0 st0 rdy1 c0 cyc0",
                           cpu_en, state, cmd_ready, stop_cause, cycles);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc = 4'd0;
  endtask

  task automatic test_random();
    int exp_cyc, halt_at;
    logic [1:0] exp_cause, ec;
    logic [1:0] exp_state;
    do_reset();
    exp_cyc = 0;
    exp_cause = CAUSE_NONE;
    exp_state = ST_IDLE;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 16; i++) begin
        prog_i[i] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        prog_m[i] = 4'($urandom_range(0, 15));
      end
      bp_adr = 4'($urandom_range(0, 15));
      halt_at = $urandom_range(0, 20);
      issue($urandom_range(0, 1) ? CMD_HALT : CMD_NOP);
      checks++; if (state !== exp_state || stop_cause !== exp_cause) begin
        failures++; $display("FAIL rnd_idle it%0d got=%0d/%0d exp=%0d/%0d", it, state, stop_cause, exp_state, exp_cause);
      end
      issue(CMD_RUN);
      checks++; if (state !== 2'b01 || stop_cause !== 2'b00) begin failures++; $display("FAIL rnd_enter it%0d got=%0d/%0d exp=1/0", it, state, stop_cause); end
      model_run(pc, halt_at, bp_adr, ec);
      exp_cyc += exp_q.size();
      run_until_stop(halt_at);
      checks++; if (timed_out || !trace_ok()) begin failures++; $display("FAIL rnd_trace it%0d got=%p exp=%p", it, act_q, exp_q); end
      checks++; if (stop_cause !== ec || state !== 2'b11) begin failures++; $display("FAIL rnd_cause it%0d got=%0d st%0d exp=%0d st3", it, stop_cause, state, ec); end
      checks++; if (cycles !== 8'(exp_cyc) || cycles4 !== 4'(exp_cyc)) begin
        failures++; $display("FAIL rnd_cycles it%0d got=%0d/%0d exp=%0d", it, cycles, cycles4, exp_cyc);
      end
      checks++; if (ready_bad != 0) begin failures++; $display("FAIL rnd_ready it%0d got=%0d bad exp=0", it, ready_bad); end
      exp_cause = ec;
      exp_state = ST_STOPPED;
    end
  endtask

  initial begin
    load_linear();
    pc = 4'd0;
    #2;
    test_reset();
    test_run_halt();
    test_step();
    test_self_loop();
    test_breakpoint();
    test_wrap();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
